// File: rtl/axis_rate_limit_pkg.sv
// -----------------------------------------------------------------------------
// axis_rate_limit_pkg
// Shared constants and types for the AXI-Stream rate limiter.
//   - DATA_WIDTH_DEFAULT / RATE_WIDTH_DEFAULT : default parameter values
//   - ACC_GUARD_BITS / ACC_WIDTH              : debt accumulator sizing; one
//     guard bit above the rate width lets debt build up past one full denom
//   - beat_t                                  : {tlast, tuser, tdata} beat at
//     the default data width
//   - beat_width()                            : flattened beat width for any
//     data width, used to size the skid storage
// -----------------------------------------------------------------------------
package axis_rate_limit_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int RATE_WIDTH_DEFAULT = 8;
  localparam int ACC_GUARD_BITS     = 1;
  localparam int ACC_WIDTH          = RATE_WIDTH_DEFAULT + ACC_GUARD_BITS;
  localparam int BEAT_SIDEBAND_W    = 2;

  typedef struct packed {
    logic                          tlast;
    logic                          tuser;
    logic [DATA_WIDTH_DEFAULT-1:0] tdata;
  } beat_t;

  function automatic int beat_width(input int data_w);
    return data_w + BEAT_SIDEBAND_W;
  endfunction

endpackage

// File: rtl/axis_register.sv
// -----------------------------------------------------------------------------
// axis_register
// Two-entry skid buffer (output register + temp register) with a registered
// upstream ready. Owns all data-path storage of the rate limiter.
//   clk, rst   : clock, synchronous active-high reset
//   i_data     : upstream payload (WIDTH bits)
//   i_valid    : upstream valid
//   o_ready    : upstream ready, straight from a flop
//   o_data     : downstream payload
//   o_valid    : downstream valid
//   i_ready    : downstream ready
// Latency is one cycle; full throughput while i_ready stays high.
// -----------------------------------------------------------------------------
module axis_register
  import axis_rate_limit_pkg::*;
#(
  parameter int WIDTH = beat_width(DATA_WIDTH_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_tmp_data;
  logic             r_out_valid;
  logic             r_tmp_valid;
  logic             r_ready;

  logic             w_in_xfer;
  logic             w_out_free;

  assign w_in_xfer  = i_valid & r_ready;
  // The output register can take a new beat this cycle if it is empty or
  // its current beat is leaving.
  assign w_out_free = ~r_out_valid | i_ready;

  assign o_ready = r_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

  // ---- control: valid flags and registered ready ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_tmp_valid <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      if (r_tmp_valid) begin
        // Temp holds a beat, so the output register is necessarily full;
        // drain temp into it as soon as downstream takes the current beat.
        if (i_ready) begin
          r_tmp_valid <= 1'b0;
          r_ready     <= 1'b1;
        end
      end else if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        if (!w_out_free) begin
          // Downstream stalled on the same cycle a beat arrived: park it in
          // temp and drop ready so nothing further is accepted.
          r_tmp_valid <= 1'b1;
          r_ready     <= 1'b0;
        end else begin
          r_ready     <= 1'b1;
        end
      end else begin
        if (i_ready) begin
          r_out_valid <= 1'b0;
        end
        r_ready <= 1'b1;
      end
    end
  end

  // ---- data: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
    end else if (r_tmp_valid) begin
      if (i_ready) begin
        r_out_data <= r_tmp_data;
      end
    end else if (w_in_xfer && w_out_free) begin
      r_out_data <= i_data;
    end
  end

  // ---- data: temp register (contents meaningless while r_tmp_valid=0) ----
  always_ff @(posedge clk) begin
    if (!r_tmp_valid && w_in_xfer && !w_out_free) begin
      r_tmp_data <= i_data;
    end
  end

endmodule

// File: rtl/axis_rate_limit.sv
// -----------------------------------------------------------------------------
// axis_rate_limit
// AXI-Stream throttle limiting accepted beats to rate_num/rate_denom per
// cycle with a saturating debt accumulator. Optional frame mode only pauses
// between frames so a frame is never split by a stall.
//   clk, rst            : clock, synchronous active-high reset
//   input_axis_*        : upstream slave port (tready is registered)
//   output_axis_*       : downstream master port (registered via skid)
//   rate_num            : credits refunded every cycle
//   rate_denom          : credits charged per accepted beat
//   rate_by_frame       : 1 = pause only while no frame is in progress
// -----------------------------------------------------------------------------
module axis_rate_limit
  import axis_rate_limit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int RATE_WIDTH = RATE_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  input  logic [RATE_WIDTH-1:0] rate_num,
  input  logic [RATE_WIDTH-1:0] rate_denom,
  input  logic                  rate_by_frame
);

  localparam int ACC_W  = RATE_WIDTH + ACC_GUARD_BITS;
  localparam int SUM_W  = ACC_W + 1;
  localparam int BEAT_W = beat_width(DATA_WIDTH);

  // Charge/refund the accumulator with floor at zero and ceiling at the
  // register's full scale, so no rate programming can make it wrap.
  function automatic logic [ACC_W-1:0] acc_update(
    input logic [ACC_W-1:0]      acc,
    input logic                  charge,
    input logic [RATE_WIDTH-1:0] num,
    input logic [RATE_WIDTH-1:0] den
  );
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] refund;
    logic [SUM_W-1:0] ceiling;
    sum     = SUM_W'(acc) + (charge ? SUM_W'(den) : '0);
    refund  = SUM_W'(num);
    ceiling = SUM_W'({ACC_W{1'b1}});
    if (sum <= refund) begin
      return '0;
    end
    sum = sum - refund;
    if (sum > ceiling) begin
      return '1;
    end
    return sum[ACC_W-1:0];
  endfunction

  logic [ACC_W-1:0]  r_acc;
  logic              r_in_frame;
  logic              r_pause;

  logic [ACC_W-1:0]  w_acc_next;
  logic              w_in_frame_next;
  logic              w_pause_next;
  logic              w_stage_ready;
  logic              w_stage_valid;
  logic              w_accept;
  logic [BEAT_W-1:0] w_in_beat;
  logic [BEAT_W-1:0] w_out_beat;

  // Both terms are flops, so upstream ready never glitches.
  assign input_axis_tready = w_stage_ready & ~r_pause;
  assign w_accept          = input_axis_tvalid & input_axis_tready;
  assign w_stage_valid     = input_axis_tvalid & ~r_pause;

  assign w_acc_next = acc_update(r_acc, w_accept, rate_num, rate_denom);

  always_comb begin
    w_in_frame_next = r_in_frame;
    if (w_accept) begin
      w_in_frame_next = ~input_axis_tlast;
    end
  end

  // Pause is evaluated one cycle ahead from next-state values so it can be
  // held in a flop; a rate change therefore reaches ready one cycle later.
  assign w_pause_next = (w_acc_next >= ACC_W'(rate_num)) &
                        ~(rate_by_frame & w_in_frame_next);

  // ---- rate control state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_in_frame <= 1'b0;
      r_pause    <= 1'b0;
    end else begin
      r_acc      <= w_acc_next;
      r_in_frame <= w_in_frame_next;
      r_pause    <= w_pause_next;
    end
  end

  assign w_in_beat = {input_axis_tlast, input_axis_tuser, input_axis_tdata};
  assign {output_axis_tlast, output_axis_tuser, output_axis_tdata} = w_out_beat;

  // ---- data path: skid stage ----
  axis_register #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_in_beat),
    .i_valid (w_stage_valid),
    .o_ready (w_stage_ready),
    .o_data  (w_out_beat),
    .o_valid (output_axis_tvalid),
    .i_ready (output_axis_tready)
  );

endmodule

// File: tb/tb_axis_rate_limit.sv
module tb_axis_rate_limit;
  import axis_rate_limit_pkg::*;

  localparam int DW = DATA_WIDTH_DEFAULT;
  localparam int RW = RATE_WIDTH_DEFAULT;
  localparam int ACC_MAX = (1 << ACC_WIDTH) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic          in_user = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          out_user;
  logic [RW-1:0] rate_num = 8'd1;
  logic [RW-1:0] rate_den = 8'd1;
  logic          by_frame = 1'b0;

  always #5 clk = ~clk;

  axis_rate_limit #(.DATA_WIDTH(DW), .RATE_WIDTH(RW)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_data),
    .input_axis_tvalid  (in_valid),
    .input_axis_tready  (in_ready),
    .input_axis_tlast   (in_last),
    .input_axis_tuser   (in_user),
    .output_axis_tdata  (out_data),
    .output_axis_tvalid (out_valid),
    .output_axis_tready (out_ready),
    .output_axis_tlast  (out_last),
    .output_axis_tuser  (out_user),
    .rate_num           (rate_num),
    .rate_denom         (rate_den),
    .rate_by_frame      (by_frame)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int    acc_cyc[$];
  int    cyc = 0;
  int    m_acc = 0;
  bit    m_inf = 1'b0;
  bit    m_pause;
  bit    rst_q = 1'b0;
  bit    prev_ordy = 1'b0;
  logic [RW-1:0] prev_num = '0;
  bit    prev_bf = 1'b0;
  bit    rand_ordy = 1'b0;

  function automatic void chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Downstream ready: random or held high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ordy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor + reference model, evaluated mid-cycle.
  initial begin
    beat_t got;
    beat_t e;
    int    nxt;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (rst_q) begin
          chk("rst_out_valid", int'(out_valid), 0);
          chk("rst_in_ready", int'(in_ready), 0);
          chk("rst_out_beat", int'({out_last, out_user, out_data}), 0);
        end
        exp_q.delete();
        m_acc = 0;
        m_inf = 1'b0;
      end else begin
        if (rst_q) begin
          chk("post_rst_out_valid", int'(out_valid), 0);
          chk("post_rst_in_ready", int'(in_ready), 0);
        end
        chk("acc_value", int'(dut.r_acc), m_acc);
        m_pause = (m_acc >= int'(rate_num)) && !(by_frame && m_inf);
        if (!rst_q && prev_num == rate_num && prev_bf == by_frame) begin
          if (m_pause) chk("ready_while_paused", int'(in_ready), 0);
          else if (prev_ordy) chk("ready_while_unpaused", int'(in_ready), 1);
        end
        if (out_valid && out_ready) begin
          got = {out_last, out_user, out_data};
          if (exp_q.size() == 0) begin
            chk("out_unexpected_beat", int'(got), -1);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", int'(got), int'(e));
          end
        end
        nxt = m_acc - int'(rate_num);
        if (in_valid && in_ready) begin
          e.tlast = in_last;
          e.tuser = in_user;
          e.tdata = in_data;
          exp_q.push_back(e);
          acc_cyc.push_back(cyc);
          m_inf = !in_last;
          nxt = nxt + int'(rate_den);
        end
        if (nxt < 0) nxt = 0;
        if (nxt > ACC_MAX) nxt = ACC_MAX;
        m_acc = nxt;
      end
      rst_q     = rst;
      prev_ordy = out_ready;
      prev_num  = rate_num;
      prev_bf   = by_frame;
      cyc++;
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rates(input int num, input int den, input bit bf);
    rate_num = RW'(num);
    rate_den = RW'(den);
    by_frame = bf;
    idle(2);
  endtask

  task automatic wait_drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || m_acc != 0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_within_bound", int'(n < 5000), 1);
    idle(2);
  endtask

  task automatic send(input int nbeats, input int flen, input int vprob,
                      input int base);
    for (int i = 0; i < nbeats; i++) begin
      int waitc;
      in_data = DW'(base + i);
      in_last = ((i % flen) == flen - 1);
      in_user = 1'($urandom_range(0, 1));
      while (int'($urandom_range(0, 99)) >= vprob) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      waitc = 0;
      forever begin
        @(negedge clk);
        if (in_ready && !rst) begin
          @(posedge clk);
          #1;
          break;
        end
        waitc++;
        if (waitc > 2000) break;
        @(posedge clk);
        #1;
      end
      if (waitc > 2000) begin
        chk("drive_timeout", waitc, 0);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int s;
    int k;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // 3/4: three accepts then one stall, 30 beats in 40 cycles.
    set_rates(3, 4, 1'b0);
    acc_cyc.delete();
    s = cyc;
    send(34, 4, 100, 0);
    k = 0;
    foreach (acc_cyc[i]) begin
      if (acc_cyc[i] < s + 40) begin
        k++;
        chk("r34_pattern_slot", int'((acc_cyc[i] - s) % 4 != 3), 1);
      end
    end
    chk("r34_beats_in_40", k, 30);
    wait_drain();

    // 1/4: one accept every 4 cycles.
    set_rates(1, 4, 1'b0);
    acc_cyc.delete();
    s = cyc;
    send(12, 4, 100, 40);
    for (int i = 0; i < 12; i++) chk("r14_offset", acc_cyc[i] - s, i * 4);
    wait_drain();

    // 2/5: accepts at 0,2,5,7,10,...
    set_rates(2, 5, 1'b0);
    acc_cyc.delete();
    s = cyc;
    send(12, 4, 100, 60);
    for (int i = 0; i < 12; i++)
      chk("r25_offset", acc_cyc[i] - s, (i / 2) * 5 + (i % 2) * 2);
    wait_drain();

    // Frame mode: 6-beat frames contiguous, 18 idle cycles between.
    set_rates(1, 4, 1'b1);
    acc_cyc.delete();
    send(18, 6, 100, 80);
    for (int i = 1; i < 18; i++)
      chk((i % 6 == 0) ? "frame_gap" : "frame_contig",
          acc_cyc[i] - acc_cyc[i-1], (i % 6 == 0) ? 19 : 1);
    wait_drain();

    // Unthrottled, random downstream ready, 1000 incrementing beats.
    set_rates(1, 1, 1'b0);
    rand_ordy = 1'b1;
    send(1000, 7, 100, 0);
    rand_ordy = 1'b0;
    wait_drain();

    // Random rates, frame mode, valid and ready.
    for (int seg = 0; seg < 6; seg++) begin
      set_rates(int'($urandom_range(1, 6)), int'($urandom_range(1, 8)),
                1'($urandom_range(0, 1)));
      rand_ordy = 1'b1;
      send(80, int'($urandom_range(1, 8)), 70, seg * 37);
      rand_ordy = 1'b0;
      wait_drain();
    end

    // Reset on 3rd beat of a 5-beat frame, then a fresh frame.
    set_rates(1, 1, 1'b0);
    send(2, 5, 100, 'h50);
    in_data  = 8'h52;
    in_last  = 1'b0;
    in_user  = 1'b1;
    in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!in_ready) @(posedge clk);
    end while (!in_ready && k < 100);
    chk("rst_test_third_beat_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_next_out_valid", int'(out_valid), 0);
    chk("rst_next_in_ready", int'(in_ready), 0);
    chk("rst_next_acc", int'(dut.r_acc), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    send(5, 5, 100, 'hA0);
    wait_drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rate_limit.md
Name: axis_rate_limit

Overview:
- Single-clock AXI-Stream throttle placed directly downstream of axis_async_fifo, on its output_clk domain.
- Caps the accepted beat rate to rate_num/rate_denom beats per cycle using a saturating debt accumulator.
- Frame mode optionally holds off pausing until a frame boundary, so frames are never split by a stall.
- Output is registered through a skid stage, so input_axis_tready is a register output.

Parameters:
DATA_WIDTH, 8, tdata width in bits
RATE_WIDTH, 8, width of rate_num and rate_denom

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
input_axis_tdata  input  DATA_WIDTH  upstream data
input_axis_tvalid  input  1  upstream valid
input_axis_tready  output  1  upstream ready (registered)
input_axis_tlast  input  1  end of frame
input_axis_tuser  input  1  user/error flag
output_axis_tdata  output  DATA_WIDTH  downstream data
output_axis_tvalid  output  1  downstream valid
output_axis_tready  input  1  downstream ready
output_axis_tlast  output  1  end of frame
output_axis_tuser  output  1  user flag
rate_num  input  RATE_WIDTH  credits refunded per cycle
rate_denom  input  RATE_WIDTH  credits charged per accepted beat
rate_by_frame  input  1  1 = pause only between frames

Behaviour:
- Reset: rst sampled on clk. Output values while rst=1 and on the first cycle after it falls:
  - output_axis_tvalid=0, input_axis_tready=0
  - output data/last/user = 0
  - acc=0, in_frame=0, skid empty
- Cycle after rst deasserts: input_axis_tready may rise.
- Reset mid-frame: the partial frame is discarded; no tlast is synthesised.
- Accumulator acc: unsigned, width RATE_WIDTH+1.
  - Per cycle: acc_next = max(0, acc + (accept ? rate_denom : 0) - rate_num), computed at RATE_WIDTH+2 bits, then stored.
- Accept (transfer into the skid/output stage) = input_axis_tvalid & input_axis_tready & ~pause.
- pause:
  - rate_by_frame=0: pause = (acc >= rate_num).
  - rate_by_frame=1: pause = (acc >= rate_num) & ~in_frame.
  - Effective input_axis_tready = stage_ready & ~pause. Both terms are registered, so ready stays glitch-free.
- in_frame: set on an accept with tlast=0; cleared on an accept with tlast=1.
- Rate cases:
  - rate_num >= rate_denom: acc never leaves 0, so no throttling.
  - rate_num = 0: at most one beat is accepted after acc returns to 0, then everything blocks. Software must not program 0 in service.
- Rate inputs may change any cycle and take effect on the next acc update. Behaviour stays defined (saturating arithmetic, no wrap).
- Data path: 2-entry skid (output register + temp register).
  - Latency is 1 cycle, input accept to output_axis_tvalid.
  - Full throughput when unthrottled and output_axis_tready=1.
  - No beat is lost or duplicated when output_axis_tready drops while input is accepted.
- Output beats appear in input order, with tlast/tuser carried unchanged.
- Simultaneous accept and output_axis_tready drop: the beat goes to the temp register, and input_axis_tready falls the next cycle.

Decomposition:
- Package axis_rate_limit_pkg:
  - constants RATE_WIDTH_DEFAULT=8 and ACC_WIDTH=RATE_WIDTH+1
  - packed beat typedef {tlast, tuser, tdata} sized by DATA_WIDTH
- Sub-module axis_register: the 2-entry skid with registered ready. It is reusable and owns all data-path storage.
- The top level holds only the accumulator, in_frame, and pause logic.

Test Plan:
- num=3, denom=4, by_frame=0, continuous valid, output_axis_tready=1 for 40 cycles -> exactly 30 output beats, in a repeating 3-on/1-off tready pattern.
- num=1, denom=4 -> one accept every 4 cycles. acc after each accept reads 3,2,1,0.
- num=2, denom=5 -> accept cycles at offsets 0,2,5,7,10,… (2 per 5); data order preserved.
- by_frame=1, num=1, denom=4, 6-beat frames back to back -> each frame passes in 6 contiguous cycles. The next frame starts only after acc decays to 0 (24-6=18 idle cycles for the first gap).
- Random output_axis_tready (50%), unthrottled (num=denom=1), 1000 beats with incrementing tdata -> output sequence identical to input, tlast/tuser intact, no drops or duplicates.
- rst asserted on the 3rd beat of a 5-beat frame -> tvalid/tready=0 and acc=0 on the next cycle. After release, the next frame is delivered intact and the partial frame is never completed.
